// File: rtl/cache_pkg.sv
// Shared types and constants for the two-way write-through data cache.
package cache_pkg;

  localparam int SET_BITS_DEF = 6;
  localparam int TAG_BITS_DEF = 10;
  localparam int NUM_WAYS     = 2;

  localparam logic WAY0 = 1'b0;
  localparam logic WAY1 = 1'b1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_MISS = 2'd1,
    WR_THRU = 2'd2
  } state_e;

  // Combined result of looking the current address up in both ways.
  typedef struct packed {
    logic        hit;
    logic        way;
    logic [31:0] data;
  } lookup_t;

  // Fill target: an empty way first (way0 before way1), otherwise the LRU way.
  function automatic logic pick_victim(input logic [1:0] vld, input logic lru);
    if (!vld[0])      return WAY0;
    else if (!vld[1]) return WAY1;
    else              return lru;
  endfunction

endpackage

// File: rtl/cache_way.sv
// One cache way: per-set valid/tag/data with a single write port and a
// combinational lookup on the same index.
module cache_way
  import cache_pkg::*;
#(
  parameter int SET_BITS = SET_BITS_DEF,
  parameter int TAG_BITS = TAG_BITS_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [SET_BITS-1:0] index,
  input  logic [TAG_BITS-1:0] tag,
  input  logic                wr_en,
  input  logic [31:0]         wr_data,
  output logic                hit,
  output logic                valid,
  output logic [31:0]         data
);

  localparam int SETS = 1 << SET_BITS;

  logic [SETS-1:0]     vld_q;
  logic [TAG_BITS-1:0] tag_q  [SETS];
  logic [31:0]         data_q [SETS];

  always_ff @(posedge clk) begin
    if (rst)        vld_q        <= '0;
    else if (wr_en) vld_q[index] <= 1'b1;
  end

  // Tag and data arrays are gated by valid, so they need no reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_q[index]  <= tag;
      data_q[index] <= wr_data;
    end
  end

  assign valid = vld_q[index];
  assign hit   = valid && (tag_q[index] == tag);
  assign data  = data_q[index];

endmodule

// File: rtl/cache_ctrl.sv
// Two-way set-associative, write-through, no-write-allocate data cache in
// front of SRAM_CTR. Define CACHE_STATS_EN to add hit/miss counters.
module cache_ctrl
  import cache_pkg::*;
#(
  parameter int SET_BITS = SET_BITS_DEF,
  parameter int TAG_BITS = TAG_BITS_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MEM_R_EN,
  input  logic        MEM_W_EN,
  input  logic [31:0] address,
  input  logic [31:0] writeData,
  output logic [31:0] readData,
  output logic        CACHE_NOT_READY,
  output logic        sram_r_en,
  output logic        sram_w_en,
  output logic [15:0] sram_address,
  output logic [31:0] sram_writeData,
  input  logic [31:0] sram_readData,
  input  logic        SRAM_NOT_READY
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);

  localparam int SETS = 1 << SET_BITS;

  logic [15:0]         wa;
  logic [SET_BITS-1:0] idx;
  logic [TAG_BITS-1:0] tag;

  logic [NUM_WAYS-1:0]        way_hit, way_vld, way_we;
  logic [NUM_WAYS-1:0][31:0]  way_data;
  logic [31:0]                way_wdata;

  lookup_t   lk;
  logic      victim;
  logic [SETS-1:0] lru_q;

  state_e state_q, state_d;
  logic   fill, wr_upd, lru_upd, lru_way;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{address[31:18], address[1:0]};

  assign wa  = address[17:2];
  assign idx = wa[SET_BITS-1:0];
  assign tag = wa[15:SET_BITS];

  for (genvar w = 0; w < NUM_WAYS; w++) begin : g_way
    cache_way #(
      .SET_BITS (SET_BITS),
      .TAG_BITS (TAG_BITS)
    ) u_way (
      .clk     (clk),
      .rst     (rst),
      .index   (idx),
      .tag     (tag),
      .wr_en   (way_we[w]),
      .wr_data (way_wdata),
      .hit     (way_hit[w]),
      .valid   (way_vld[w]),
      .data    (way_data[w])
    );
  end

  assign lk.hit  = |way_hit;
  assign lk.way  = way_hit[1] ? WAY1 : WAY0;
  assign lk.data = way_data[lk.way];
  assign victim  = pick_victim(way_vld, lru_q[idx]);

  // A fill and a write-hit update never coincide: they come from different states.
  assign way_wdata = fill ? sram_readData : writeData;
  assign way_we[0] = ~rst & ((fill & (victim == WAY0)) | (wr_upd & (lk.way == WAY0)));
  assign way_we[1] = ~rst & ((fill & (victim == WAY1)) | (wr_upd & (lk.way == WAY1)));

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst)          lru_q      <= '0;
    else if (lru_upd) lru_q[idx] <= ~lru_way;
  end

  always_comb begin
    state_d         = state_q;
    CACHE_NOT_READY = 1'b0;
    readData        = '0;
    fill            = 1'b0;
    wr_upd          = 1'b0;
    lru_upd         = 1'b0;
    lru_way         = lk.way;
    unique case (state_q)
      IDLE: begin
        if (MEM_W_EN) begin
          CACHE_NOT_READY = 1'b1;
          state_d         = WR_THRU;
        end else if (MEM_R_EN) begin
          if (lk.hit) begin
            readData = lk.data;
            lru_upd  = 1'b1;
          end else begin
            CACHE_NOT_READY = 1'b1;
            state_d         = RD_MISS;
          end
        end
      end
      RD_MISS: begin
        CACHE_NOT_READY = SRAM_NOT_READY;
        if (!SRAM_NOT_READY) begin
          readData = sram_readData;
          fill     = 1'b1;
          lru_upd  = 1'b1;
          lru_way  = victim;
          state_d  = IDLE;
        end
      end
      WR_THRU: begin
        CACHE_NOT_READY = SRAM_NOT_READY;
        if (!SRAM_NOT_READY) begin
          state_d = IDLE;
          if (lk.hit) begin
            wr_upd  = 1'b1;
            lru_upd = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Registered-state decode keeps MEM_*_EN off the SRAM request path.
  assign sram_r_en      = (state_q == RD_MISS);
  assign sram_w_en      = (state_q == WR_THRU);
  assign sram_address   = wa;
  assign sram_writeData = writeData;

`ifdef CACHE_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (state_q == IDLE && MEM_R_EN && !MEM_W_EN && lk.hit)
        hit_count <= hit_count + 32'd1;
      if (state_q == RD_MISS && !SRAM_NOT_READY)
        miss_count <= miss_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cache_ctrl.sv
// Self-checking bench for cache_ctrl: directed table, reset/stat sequences,
// and random traffic against a recency-list reference model.
module tb_cache_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        MEM_R_EN, MEM_W_EN;
  logic [31:0] address, writeData, readData;
  logic        CACHE_NOT_READY;
  logic        sram_r_en, sram_w_en;
  logic [15:0] sram_address;
  logic [31:0] sram_writeData, sram_readData;
  logic        SRAM_NOT_READY;
`ifdef CACHE_STATS_EN
  logic [31:0] hit_count, miss_count;
`endif

  always #5 clk = ~clk;

  cache_ctrl dut (
    .clk             (clk),
    .rst             (rst),
    .MEM_R_EN        (MEM_R_EN),
    .MEM_W_EN        (MEM_W_EN),
    .address         (address),
    .writeData       (writeData),
    .readData        (readData),
    .CACHE_NOT_READY (CACHE_NOT_READY),
    .sram_r_en       (sram_r_en),
    .sram_w_en       (sram_w_en),
    .sram_address    (sram_address),
    .sram_writeData  (sram_writeData),
    .sram_readData   (sram_readData),
    .SRAM_NOT_READY  (SRAM_NOT_READY)
`ifdef CACHE_STATS_EN
    ,
    .hit_count       (hit_count),
    .miss_count      (miss_count)
`endif
  );

  function automatic logic [31:0] init_word(input logic [15:0] a);
    if (a == 16'h0040) return 32'hDEADBEEF;
    return {a ^ 16'h5A5A, a};
  endfunction

  // SRAM_CTR stand-in: stalls 1..3 cycles per request, never ready on the first cycle.
  logic [31:0] sram_mem [65536];
  bit          sram_wr  [65536];
  int unsigned sr_cnt, sr_lat;

  assign SRAM_NOT_READY = (sram_r_en || sram_w_en) && (sr_cnt < sr_lat);
  always_comb sram_readData = sram_wr[sram_address] ? sram_mem[sram_address]
                                                    : init_word(sram_address);

  always @(posedge clk) begin
    if (rst || !(sram_r_en || sram_w_en)) begin
      sr_cnt <= 0;
      sr_lat <= $urandom_range(1, 3);
    end else begin
      sr_cnt <= sr_cnt + 1;
      if (sram_w_en && !SRAM_NOT_READY) begin
        sram_mem[sram_address] <= sram_writeData;
        sram_wr[sram_address]  <= 1'b1;
      end
    end
  end

  // Reference: memory image plus per-set recency list (front = most recent, max 2).
  logic [31:0] refm [int];
  int unsigned rq [64][$];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < 64; s++) rq[s].delete();
  endtask

  task automatic model(input bit wr, input logic [15:0] wa, input logic [31:0] wd,
                       output bit eh, output logic [31:0] ed);
    int s, pos;
    int unsigned t;
    s   = int'(wa[5:0]);
    t   = int'(wa[15:6]);
    pos = -1;
    for (int i = 0; i < rq[s].size(); i++) if (rq[s][i] == t) pos = i;
    eh = (pos >= 0);
    ed = refm.exists(int'(wa)) ? refm[int'(wa)] : init_word(wa);
    if (wr) refm[int'(wa)] = wd;
    if (eh) begin
      rq[s].delete(pos);
      rq[s].push_front(t);
    end else if (!wr) begin
      rq[s].push_front(t);
      if (rq[s].size() > 2) void'(rq[s].pop_back());
    end
  endtask

  // One pipeline access; hit means the load completed with no stall cycle.
  task automatic access(input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                        output bit hit, output logic [31:0] rd,
                        output bit req_seen, output bit addr_ok);
    int n;
    @(posedge clk); #1;
    MEM_R_EN  = !wr;
    MEM_W_EN  = wr;
    address   = addr;
    writeData = wd;
    n = 0; req_seen = 0; addr_ok = 1;
    @(negedge clk);
    hit = !CACHE_NOT_READY;
    while (CACHE_NOT_READY && n < 50) begin
      if (wr ? sram_w_en : sram_r_en) begin
        req_seen = 1;
        if (sram_address !== addr[17:2]) addr_ok = 0;
      end
      n++;
      @(negedge clk);
    end
    rd = readData;
    if (n >= 50) begin
      n_cmp++; n_bad++;
      $display("FAIL timeout: access %h still stalled after %0d cycles", addr, n);
    end
    @(posedge clk); #1;
    MEM_R_EN = 0;
    MEM_W_EN = 0;
  endtask

  task automatic do_op(input string nm, input bit wr, input logic [31:0] addr,
                       input logic [31:0] wd, input bit use_tbl,
                       input bit t_hit, input logic [31:0] t_rd);
    bit eh, hit, seen, aok;
    logic [31:0] ed, rd;
    model(wr, addr[17:2], wd, eh, ed);
    if (use_tbl) begin eh = t_hit; ed = t_rd; end
    access(wr, addr, wd, hit, rd, seen, aok);
    if (!wr) begin
      chk({nm, "_hit"}, {31'd0, hit}, {31'd0, eh});
      chk({nm, "_data"}, rd, ed);
    end
    if (wr || !eh) begin
      chk({nm, "_sram_req"}, {31'd0, seen}, 32'd1);
      chk({nm, "_sram_addr"}, {31'd0, aok}, 32'd1);
    end
  endtask

  task automatic do_reset();
    rst = 1;
    MEM_R_EN = 0; MEM_W_EN = 0;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    model_reset();
  endtask

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wd;
    bit          exp_hit;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t tbl [10];

  initial begin
    bit eh;
    logic [31:0] ed, r;
    logic [15:0] wa;
    int k;

    tbl[0] = '{0, 32'h0000_0100, 32'h0,         0, 32'hDEADBEEF};
    tbl[1] = '{0, 32'h0000_0100, 32'h0,         1, 32'hDEADBEEF};
    tbl[2] = '{0, 32'h0001_0100, 32'h0,         0, init_word(16'h4040)};
    tbl[3] = '{0, 32'h0002_0100, 32'h0,         0, init_word(16'h8040)};
    tbl[4] = '{0, 32'h0001_0100, 32'h0,         1, init_word(16'h4040)};
    tbl[5] = '{0, 32'h0000_0100, 32'h0,         0, 32'hDEADBEEF};
    tbl[6] = '{1, 32'h0000_0100, 32'h12345678,  1, 32'h0};
    tbl[7] = '{0, 32'h0000_0100, 32'h0,         1, 32'h12345678};
    tbl[8] = '{1, 32'h0000_0200, 32'hCAFEF00D,  0, 32'h0};
    tbl[9] = '{0, 32'h0000_0200, 32'h0,         0, 32'hCAFEF00D};

    address = 0; writeData = 0;
    do_reset();

    @(negedge clk);
    chk("rst_sram_r_en", {31'd0, sram_r_en}, 32'd0);
    chk("rst_sram_w_en", {31'd0, sram_w_en}, 32'd0);
    chk("rst_not_ready", {31'd0, CACHE_NOT_READY}, 32'd0);
    chk("rst_readData", readData, 32'd0);

    for (int i = 0; i < 10; i++)
      do_op($sformatf("tbl%0d", i), tbl[i].wr, tbl[i].addr, tbl[i].wd, 1,
            tbl[i].exp_hit, tbl[i].exp_rd);

    // Reset in the middle of a read miss: request drops, nothing is filled.
    @(posedge clk); #1;
    MEM_R_EN = 1; address = 32'h300;
    k = 0;
    @(negedge clk);
    while (!sram_r_en && k < 10) begin k++; @(negedge clk); end
    chk("midrst_req_seen", {31'd0, sram_r_en}, 32'd1);
    rst = 1; MEM_R_EN = 0;
    @(posedge clk); #1;
    chk("midrst_sram_r_en", {31'd0, sram_r_en}, 32'd0);
    chk("midrst_not_ready", {31'd0, CACHE_NOT_READY}, 32'd0);
    chk("midrst_readData", readData, 32'd0);
    rst = 0;
    model_reset();
    do_op("midrst_reread", 0, 32'h300, 0, 1, 0, init_word(16'h00C0));

    // Hit/miss mix: 3 misses, 5 hits across three sets.
    do_reset();
    do_op("mix0", 0, 32'h1000, 0, 0, 0, 0);
    do_op("mix1", 0, 32'h1000, 0, 0, 0, 0);
    do_op("mix2", 0, 32'h1000, 0, 0, 0, 0);
    do_op("mix3", 0, 32'h1004, 0, 0, 0, 0);
    do_op("mix4", 0, 32'h1004, 0, 0, 0, 0);
    do_op("mix5", 0, 32'h1008, 0, 0, 0, 0);
    do_op("mix6", 0, 32'h1008, 0, 0, 0, 0);
    do_op("mix7", 0, 32'h1000, 0, 0, 0, 0);
`ifdef CACHE_STATS_EN
    chk("stats_miss_count", miss_count, 32'd3);
    chk("stats_hit_count", hit_count, 32'd5);
`endif

    // Random traffic on a few sets and tags to force hits, evictions and write-throughs.
    for (int i = 0; i < 300; i++) begin
      r  = $urandom();
      wa = {6'd0, 4'($urandom_range(0, 3)), 6'($urandom_range(0, 2))};
      do_op($sformatf("rnd%0d", i), ($urandom_range(0, 9) < 3), {r[31:18], wa, r[1:0]},
            $urandom(), 0, 0, 0);
    end

    // Ending read of a known line keeps the model and DUT paths aligned.
    model(0, 16'h0040, 0, eh, ed);
    do_op("final", 0, 32'h100, 0, 1, eh, ed);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cache_ctrl.md
Name: cache_ctrl

Overview:
- Two-way set-associative, write-through, no-write-allocate data cache between the MEM stage and SRAM_CTR.
- Serves read hits in zero cycles.
- Forwards read misses and all writes to SRAM_CTR over its MEM_R_EN/MEM_W_EN/SRAM_NOT_READY handshake.
- Stalls the pipeline through CACHE_NOT_READY until the access completes.

Parameters:
- SET_BITS, 6, index width; sets = 2**SET_BITS.
- TAG_BITS, 10, tag width; must equal 16 - SET_BITS.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- MEM_R_EN  in  1  pipeline load request, held until CACHE_NOT_READY=0
- MEM_W_EN  in  1  pipeline store request, held until CACHE_NOT_READY=0
- address  in  32  byte address; word address = address[17:2]
- writeData  in  32  store data
- readData  out  32  load data
- CACHE_NOT_READY  out  1  pipeline stall
- sram_r_en  out  1  to SRAM_CTR MEM_R_EN
- sram_w_en  out  1  to SRAM_CTR MEM_W_EN
- sram_address  out  16  to SRAM_CTR address (word address)
- sram_writeData  out  32  to SRAM_CTR writeData
- sram_readData  in  32  from SRAM_CTR readData
- SRAM_NOT_READY  in  1  from SRAM_CTR

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Address split: wa = address[17:2]; index = wa[SET_BITS-1:0]; tag = wa[15:SET_BITS].
- Per-set storage:
  - per way: valid, tag, 32-bit data;
  - one lru bit: lru=0 means way0 is the victim, lru=1 means way1 is the victim.
- hit = valid & tag match in either way. Both ways matching cannot occur by construction.
- FSM states: IDLE, RD_MISS, WR_THRU.
- IDLE:
  - MEM_R_EN & hit: readData = hit way data combinationally; CACHE_NOT_READY=0; lru points away from hit way at the next edge.
  - MEM_R_EN & miss: CACHE_NOT_READY=1; next state RD_MISS.
  - MEM_W_EN: CACHE_NOT_READY=1; next state WR_THRU.
  - Both R and W set: W has priority (protocol violation; the pipeline never does this).
- sram_r_en=1 only in RD_MISS; sram_w_en=1 only in WR_THRU. Both are decoded from the registered state, so there is no combinational path from MEM_*_EN.
- sram_address = wa and sram_writeData = writeData, passed straight through; the pipeline holds them stable while stalled.
- Completion:
  - In RD_MISS/WR_THRU, completion is any cycle with SRAM_NOT_READY=0.
  - The first cycle in either state always sees SRAM_NOT_READY=1, because SRAM_CTR stalls combinationally in INIT.
  - On completion, CACHE_NOT_READY=0 in that same cycle, next state IDLE, and the SRAM request drops at the edge. This prevents SRAM_CTR from re-issuing.
- RD_MISS completion:
  - readData = sram_readData combinationally.
  - Fill victim way: invalid way0 first, else invalid way1, else the lru way.
  - Set valid, tag and data; lru points away from the filled way.
- WR_THRU completion: if hit, update hit way data and set lru away from it; on miss the cache is unchanged (no allocate).
- CACHE_NOT_READY = (MEM_R_EN & ~hit | MEM_W_EN) in IDLE; = SRAM_NOT_READY in RD_MISS/WR_THRU.
- Back-to-back: a new miss may enter RD_MISS the cycle after completion; SRAM_CTR is then in INIT.
- Reset:
  - all valid and lru bits cleared; state IDLE; sram_r_en=0, sram_w_en=0.
  - readData=0 when no hit is being served.
  - Reset mid-miss aborts with no fill; SRAM_CTR shares rst.
- Data arrays carry no reset.

Optional Feature:
- CACHE_STATS_EN defined:
  - adds outputs hit_count[31:0] and miss_count[31:0].
  - hit_count increments on each IDLE read hit cycle.
  - miss_count increments on each RD_MISS completion.
  - both clear on rst and wrap at 2**32.
- Undefined: no ports and no counter logic.

Decomposition:
- Package cache_pkg: state encoding (IDLE=0, RD_MISS=1, WR_THRU=2), default SET_BITS/TAG_BITS, way-select constants.
- One sub-module, cache_way: per-way valid/tag/data array with a write port and a combinational lookup port; instantiated twice.
- FSM, LRU and muxing live in cache_ctrl.

Test Plan:
- Cold read of address 0x100 after reset, SRAM model returns 0xDEADBEEF:
  - CACHE_NOT_READY high until SRAM completion, readData=0xDEADBEEF in the release cycle.
  - A repeat read of 0x100 hits with zero stall.
- Reads of 0x100, then 0x10100 and 0x20100 (same index 0, distinct tags):
  - 0x20100 evicts 0x100's way (LRU).
  - A re-read of 0x100 misses; 0x10100 hits.
- Write 0x12345678 to cached 0x100:
  - sram_w_en asserted for the write, cache data updated.
  - The next read of 0x100 hits with 0x12345678.
- Write to uncached 0x200, then read 0x200: the read misses (no allocate) and fetches from SRAM.
- rst asserted mid-RD_MISS:
  - sram_r_en=0 next cycle, state IDLE.
  - A read of the same address misses again.
- Hit/miss mix of 3 misses and 5 hits with CACHE_STATS_EN defined: miss_count=3, hit_count=5.
